// File: rtl/usr_pkg.sv
// ============================================================================
// usr_pkg : mode and FSM encodings for univ_shift_register.   Rev 1.0
// ============================================================================
`default_nettype none

package usr_pkg;

  localparam logic [2:0] USR_HOLD = 3'd0;
  localparam logic [2:0] USR_LOAD = 3'd1;
  localparam logic [2:0] USR_SHL  = 3'd2;
  localparam logic [2:0] USR_SHR  = 3'd3;
  localparam logic [2:0] USR_ROTL = 3'd4;
  localparam logic [2:0] USR_ROTR = 3'd5;
  localparam logic [2:0] USR_ASR  = 3'd6;
  localparam logic [2:0] USR_RSVD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Only the five shifting modes may start a burst.
  function automatic logic is_shift_mode(input logic [2:0] mode);
    return (mode >= USR_SHL) && (mode <= USR_ASR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/univ_shift_register_if.sv
// ============================================================================
// univ_shift_register_if : control/data bundle of the shift register.
// o_par exists only when USR_PARITY_EN is defined.            Rev 1.0
// ============================================================================
`default_nettype none

interface univ_shift_register_if #(
  parameter int NBIT = 8
);
  localparam int CNTW = $clog2(NBIT + 1);

  logic            i_en;
  logic [2:0]      i_mode;
  logic [NBIT-1:0] i_d;
  logic            i_sil;
  logic            i_sir;
  logic            i_start;
  logic [CNTW-1:0] i_nshift;
  logic [NBIT-1:0] o_q;
  logic            o_sol;
  logic            o_sor;
  logic            o_busy;
  logic            o_done;
`ifdef USR_PARITY_EN
  logic            o_par;
`endif

  modport master (
`ifdef USR_PARITY_EN
    input  o_par,
`endif
    output i_en, i_mode, i_d, i_sil, i_sir, i_start, i_nshift,
    input  o_q, o_sol, o_sor, o_busy, o_done
  );

  modport slave (
`ifdef USR_PARITY_EN
    output o_par,
`endif
    input  i_en, i_mode, i_d, i_sil, i_sir, i_start, i_nshift,
    output o_q, o_sol, o_sor, o_busy, o_done
  );

endinterface

`default_nettype wire

// File: rtl/usr_next_value.sv
// ============================================================================
// usr_next_value : combinational next-value function of the register.
//                                                             Rev 1.0
// ============================================================================
`default_nettype none

module usr_next_value
  import usr_pkg::*;
#(
  parameter int NBIT = 8
) (
  input  logic [NBIT-1:0] q,
  input  logic [2:0]      mode,
  input  logic [NBIT-1:0] d,
  input  logic            sil,
  input  logic            sir,
  output logic [NBIT-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      USR_LOAD: q_next = d;
      USR_SHL:  q_next = {q[NBIT-2:0], sil};
      USR_SHR:  q_next = {sir, q[NBIT-1:1]};
      USR_ROTL: q_next = {q[NBIT-2:0], q[NBIT-1]};
      USR_ROTR: q_next = {q[0], q[NBIT-1:1]};
      USR_ASR:  q_next = {q[NBIT-1], q[NBIT-1:1]};
      default:  q_next = q;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/univ_shift_register.sv
// ============================================================================
// univ_shift_register : universal shift register with burst engine.
// Optional registered parity output enabled by USR_PARITY_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module univ_shift_register
  import usr_pkg::*;
#(
  parameter int NBIT = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  univ_shift_register_if.slave  bus
);

  localparam int              CNTW     = $clog2(NBIT + 1);
  localparam logic [CNTW-1:0] NBIT_CNT = CNTW'(NBIT);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

  state_t          state, state_next;
  logic [2:0]      run_mode, run_mode_next;
  logic [CNTW-1:0] count, count_next;
  logic [NBIT-1:0] q, q_next;
  logic [2:0]      op_mode;
  logic            start_ok;
  logic [CNTW-1:0] nshift_clamped;

  usr_next_value #(.NBIT(NBIT)) u_next (
    .q      (q),
    .mode   (op_mode),
    .d      (bus.i_d),
    .sil    (bus.i_sil),
    .sir    (bus.i_sir),
    .q_next (q_next)
  );

  always_comb begin
    state_next     = state;
    run_mode_next  = run_mode;
    count_next     = count;
    op_mode        = USR_HOLD;
    start_ok       = bus.i_start && is_shift_mode(bus.i_mode);
    nshift_clamped = (bus.i_nshift > NBIT_CNT) ? NBIT_CNT : bus.i_nshift;

    case (state)
      ST_IDLE: begin
        if (start_ok) begin
          run_mode_next = bus.i_mode;
          count_next    = nshift_clamped;
          if (nshift_clamped != '0) begin
            // First shift of the burst happens on the accepting edge.
            op_mode    = bus.i_mode;
            count_next = nshift_clamped - CNT_ONE;
            state_next = ST_RUN;
          end else begin
            state_next = ST_DONE;
          end
        end else if (bus.i_en) begin
          op_mode = bus.i_mode;
        end
      end
      ST_RUN: begin
        // With count exhausted RUN lingers one idle cycle before DONE.
        if (count != '0) begin
          op_mode    = run_mode;
          count_next = count - CNT_ONE;
        end else begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      run_mode <= USR_HOLD;
      count    <= '0;
      q        <= '0;
    end else begin
      state    <= state_next;
      run_mode <= run_mode_next;
      count    <= count_next;
      q        <= q_next;
    end
  end

  assign bus.o_q    = q;
  assign bus.o_sol  = q[NBIT-1];
  assign bus.o_sor  = q[0];
  assign bus.o_busy = (state == ST_RUN);
  assign bus.o_done = (state == ST_DONE);

`ifdef USR_PARITY_EN
  logic par;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      par <= 1'b0;
    end else begin
      par <= ^q_next;
    end
  end

  assign bus.o_par = par;
`endif

endmodule

`default_nettype wire
